mult_fp_pipe: RTL
=================

Name: mult_fp_pipe

Overview:
Parametrised, pipelined IEEE-754 floating-point multiplier and the successor to the combinational fp64 multiplier. Exponent and fraction widths are parameters, so one module serves both fp32 and fp64 lanes of the vector unit. It has a 3-stage registered pipeline with valid/ready handshakes on both sides, special-value handling, and overflow and underflow flags.

Parameters:
EXP_W, 11, exponent field width (8 for fp32).
FRAC_W, 52, stored fraction width without the hidden bit (23 for fp32).
Derived: W = 1+EXP_W+FRAC_W; BIAS = 2^(EXP_W-1)-1.

Ports:
I_clk  input  1  clock, rising edge
I_rst  input  1  reset, asynchronous, active-high
I_valid  input  1  operand pair present
O_ready  output  1  block accepts operands this cycle
I_a  input  W  operand A
I_b  input  W  operand B
O_valid  output  1  result present
I_ready  input  1  consumer accepts result this cycle
O_result  output  W  product
O_overflow  output  1  result overflowed to infinity; qualified by O_valid
O_underflow  output  1  result flushed to zero; qualified by O_valid

Behaviour:
- Reset: all stage valids, O_valid, O_overflow and O_underflow are 0; O_result is 0. Reset acts immediately, mid-operation included, and discards any in-flight operations.
- Global advance: en = !O_valid || I_ready. O_ready = en. An operand is accepted on I_valid && O_ready. Each stage register loads only when en=1.
- Latency is 3 cycles from acceptance to O_valid with no stall. Throughput is 1 result per cycle.
- While O_valid && !I_ready, every stage, O_result and the flags hold stable. No operand is accepted or lost.
- Bubbles propagate as valid=0. They are not collapsed.
- Stage 1 (unpack):
  - Sign = sa XOR sb.
  - Zero = exponent field == 0. Subnormals are treated as zero; there is no subnormal support.
  - Special = exponent field all ones.
  - Significands = {1, frac}.
  - Exponent sum e = Ea + Eb - BIAS, signed, EXP_W+2 bits.
- Stage 2 (multiply): registers the (2*FRAC_W+2)-bit significand product.
- Stage 3 (normalise, round, pack):
  - If product MSB = 1: take fraction from the bits below the MSB and set e = e+1. Otherwise shift by one.
  - Rounding follows the optional feature below.
  - A rounding carry-out sets the fraction to 0 and e = e+1.
- Range and special-value priority, highest first:
  1. Any NaN operand, or Inf times zero: canonical qNaN = {0, all ones, 1 followed by zeros}. Flags are 0.
  2. Any Inf operand: signed infinity. Flags are 0.
  3. Any zero operand: signed zero. Flags are 0.
  4. Final e >= 2^EXP_W - 1: signed infinity, O_overflow = 1.
  5. Final e <= 0: signed zero, O_underflow = 1.
  6. Otherwise: {sign, e[EXP_W-1:0], fraction}.
- Overflow is checked after the rounding carry is applied.

Optional Feature:
Macro MULT_FP_ROUND_EN.
- Defined: round-to-nearest-even using guard = first discarded bit, sticky = OR of the remaining discarded bits, lsb = kept LSB. Increment when guard && (sticky || lsb).
- Undefined: truncation (round toward zero). The rounding adder and carry path are absent. Latency and handshake are unchanged.

Test Plan:
- fp64, 0x3FF8000000000000 (1.5) × 0x4000000000000000 (2.0), I_ready=1 -> O_result = 0x4008000000000000 exactly 3 cycles after acceptance; flags 0.
- 0x3FF0000000000001 × 0x3FF8000000000000 (exact tie) -> 0x3FF8000000000002 with MULT_FP_ROUND_EN; 0x3FF8000000000001 without it.
- 0x7FE0000000000000 × 0x4000000000000000 -> 0x7FF0000000000000, O_overflow=1. 0x0010000000000000 × 0x3FE0000000000000 -> 0x0000000000000000, O_underflow=1. 0xBFF0000000000000 × 0x3FF0000000000000 -> 0xBFF0000000000000, flags 0.
- Specials: 0x7FF0000000000000 × 0x0000000000000000 -> 0x7FF8000000000000. 0xFFF0000000000000 × 0x4000000000000000 -> 0xFFF0000000000000.
- Backpressure: stream 6 back-to-back ops with I_ready low for 5 cycles after the first result -> O_ready=0 throughout the stall, O_result held constant, and all 6 results emerge in order with none dropped or duplicated.
- Reset mid-operation: pipeline full, assert I_rst between clock edges -> O_valid drops to 0 before the next edge. After release, the first new op completes in 3 cycles. EXP_W=8/FRAC_W=23: 0x3FC00000 × 0x40000000 -> 0x40400000.

Source files
------------

// File: rtl/mult_fp_pipe.sv
// mult_fp_pipe: 3-stage pipelined IEEE-754 multiplier with valid/ready handshakes and parametrised widths.
// Define MULT_FP_ROUND_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
module mult_fp_pipe #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  logic                        I_clk,
    input  logic                        I_rst,
    input  logic                        I_valid,
    output logic                        O_ready,
    input  logic [EXP_W+FRAC_W:0]       I_a,
    input  logic [EXP_W+FRAC_W:0]       I_b,
    output logic                        O_valid,
    input  logic                        I_ready,
    output logic [EXP_W+FRAC_W:0]       O_result,
    output logic                        O_overflow,
    output logic                        O_underflow
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * FRAC_W + 2;
    localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    logic en;
    assign en      = !O_valid || I_ready;
    assign O_ready = en;

    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic a_zero, b_zero, a_spec, b_spec;
    assign ea     = I_a[W-2 -: EXP_W];
    assign eb     = I_b[W-2 -: EXP_W];
    assign fa     = I_a[FRAC_W-1:0];
    assign fb     = I_b[FRAC_W-1:0];
    assign a_zero = ea == '0;
    assign b_zero = eb == '0;
    assign a_spec = &ea;
    assign b_spec = &eb;

    logic              v1, s1, nan1, inf1, zero1;
    logic [EW-1:0]     e1;
    logic [FRAC_W:0]   ma1, mb1;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            v1    <= 1'b0;
            s1    <= 1'b0;
            nan1  <= 1'b0;
            inf1  <= 1'b0;
            zero1 <= 1'b0;
            e1    <= '0;
            ma1   <= '0;
            mb1   <= '0;
        end else if (en) begin
            v1    <= I_valid;
            s1    <= I_a[W-1] ^ I_b[W-1];
            nan1  <= (a_spec && fa != '0) || (b_spec && fb != '0) || (a_spec && b_zero) || (b_spec && a_zero);
            inf1  <= a_spec || b_spec;
            zero1 <= a_zero || b_zero;
            e1    <= {2'b00, ea} + {2'b00, eb} - BIAS;
            ma1   <= {1'b1, fa};
            mb1   <= {1'b1, fb};
        end
    end

    logic              v2, s2, nan2, inf2, zero2;
    logic [EW-1:0]     e2;
    logic [PW-1:0]     p2;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            v2    <= 1'b0;
            s2    <= 1'b0;
            nan2  <= 1'b0;
            inf2  <= 1'b0;
            zero2 <= 1'b0;
            e2    <= '0;
            p2    <= '0;
        end else if (en) begin
            v2    <= v1;
            s2    <= s1;
            nan2  <= nan1;
            inf2  <= inf1;
            zero2 <= zero1;
            e2    <= e1;
            p2    <= {{(FRAC_W+1){1'b0}}, ma1} * {{(FRAC_W+1){1'b0}}, mb1};
        end
    end

    logic              msb, ovf, unf;
    logic [FRAC_W-1:0] fr_n, fr;
    logic [EW-1:0]     e_n, e_f;
    logic [W-1:0]      res;

    always_comb begin
        msb  = p2[PW-1];
        fr_n = msb ? p2[PW-2 -: FRAC_W] : p2[PW-3 -: FRAC_W];
        e_n  = e2 + {{(EW-1){1'b0}}, msb};
    end

`ifdef MULT_FP_ROUND_EN
    logic            lsb, guard, sticky, inc;
    logic [FRAC_W:0] rnd;
    always_comb begin
        lsb    = msb ? p2[FRAC_W+1] : p2[FRAC_W];
        guard  = msb ? p2[FRAC_W] : p2[FRAC_W-1];
        sticky = msb ? |p2[FRAC_W-1:0] : |p2[FRAC_W-2:0];
        inc    = guard && (sticky || lsb);
        rnd    = {1'b0, fr_n} + {{FRAC_W{1'b0}}, inc};
        // a carry out leaves the fraction at zero and bumps the exponent
        fr     = rnd[FRAC_W-1:0];
        e_f    = e_n + {{(EW-1){1'b0}}, rnd[FRAC_W]};
    end
`else
    logic unused_low;
    assign unused_low = ^p2[FRAC_W-1:0];
    always_comb begin
        fr  = fr_n;
        e_f = e_n;
    end
`endif

    always_comb begin
        ovf = !nan2 && !inf2 && !zero2 && !e_f[EW-1] && e_f >= EMAX;
        unf = !nan2 && !inf2 && !zero2 && (e_f[EW-1] || e_f == '0);
        res = nan2         ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}} :
              (inf2 || ovf) ? {s2, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
              (zero2 || unf) ? {s2, {(W-1){1'b0}}} :
                               {s2, e_f[EXP_W-1:0], fr};
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_valid     <= 1'b0;
            O_result    <= '0;
            O_overflow  <= 1'b0;
            O_underflow <= 1'b0;
        end else if (en) begin
            O_valid     <= v2;
            O_result    <= res;
            O_overflow  <= v2 && ovf;
            O_underflow <= v2 && unf;
        end
    end
endmodule
